// File: rtl/stereo_pkg.sv
// rtl/stereo_pkg.sv - state encoding and pattern select codes for the stereo frame source
package stereo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VSYNC  = 3'd1,
      ST_VBLANK = 3'd2,
      ST_LINE   = 3'd3,
      ST_HBLANK = 3'd4
   } state_t;

   localparam logic [1:0] PAT_RAMP  = 2'd0;
   localparam logic [1:0] PAT_CHECK = 2'd1;
   localparam logic [1:0] PAT_XOR   = 2'd2;
   localparam logic [1:0] PAT_ZERO  = 2'd3;

endpackage

// File: rtl/stereo_pattern_gen.sv
// rtl/stereo_pattern_gen.sv - combinational test pattern p(x,y,pattern)
module stereo_pattern_gen
   import stereo_pkg::*;
#(
   parameter int PIXEL_DEPTH = 18,
   parameter int XW          = 11,
   parameter int YW          = 10
) (
   input  logic [XW-1:0]        i_x,
   input  logic [YW-1:0]        i_y,
   input  logic [1:0]           i_pattern,
   output logic [PIXEL_DEPTH:0] o_px
);

   logic [PIXEL_DEPTH:0] w_x_px;
   logic [PIXEL_DEPTH:0] w_y_px;

   // Truncate or zero-extend to pixel width before combining.
   assign w_x_px = (PIXEL_DEPTH+1)'(i_x);
   assign w_y_px = (PIXEL_DEPTH+1)'(i_y);

   always_comb begin
      o_px = '0;
      case (i_pattern)
         PAT_RAMP:  o_px = w_x_px;
         PAT_CHECK: o_px = (i_x[3] ^ i_y[3]) ? '1 : '0;
         PAT_XOR:   o_px = w_x_px ^ (w_y_px << 2);
         default:   o_px = '0;
      endcase
   end

endmodule

// File: rtl/stereo_frame_source.sv
// rtl/stereo_frame_source.sv - left/right grayscale stream with Href/Vsync framing
// Right image is the left image shifted by a latched, clamped disparity.
module stereo_frame_source
   import stereo_pkg::*;
#(
   parameter int PIXEL_DEPTH     = 18,
   parameter int PX_CNT_DEPTH    = 9,
   parameter int LINE_CNT_DEPTH  = 9,
   parameter int PIXELS_PER_LINE = 499,
   parameter int LINES_PER_FRAME = 499,
   parameter int H_BLANK         = 16,
   parameter int VSYNC_LINES     = 2,
   parameter int V_BLANK         = 3,
   parameter int MAX_DISPARITY   = 19,
   parameter int DISPARITY_DEPTH = 4
) (
   input  logic                      pxclk,
   input  logic                      reset,
   input  logic                      iEnable,
   input  logic [1:0]                iPattern,
   input  logic [DISPARITY_DEPTH:0]  iDisparity,
   output logic [PIXEL_DEPTH:0]      oGrayL,
   output logic [PIXEL_DEPTH:0]      oGrayR,
   output logic                      oHref,
   output logic                      oVsync,
   output logic [LINE_CNT_DEPTH:0]   oLine,
   output logic                      oFrameDone
);

   localparam logic [PX_CNT_DEPTH:0]    X_LAST     = (PX_CNT_DEPTH+1)'(PIXELS_PER_LINE + H_BLANK);
   localparam logic [PX_CNT_DEPTH:0]    X_ACT_LAST = (PX_CNT_DEPTH+1)'(PIXELS_PER_LINE);
   localparam logic [PX_CNT_DEPTH+1:0]  X_ACT_W    = (PX_CNT_DEPTH+2)'(PIXELS_PER_LINE);
   localparam logic [LINE_CNT_DEPTH:0]  Y_LAST     = (LINE_CNT_DEPTH+1)'(LINES_PER_FRAME);
   localparam logic [LINE_CNT_DEPTH:0]  VS_LAST    = (LINE_CNT_DEPTH+1)'(VSYNC_LINES - 1);
   localparam logic [LINE_CNT_DEPTH:0]  VB_LAST    = (LINE_CNT_DEPTH+1)'(V_BLANK - 1);
   localparam logic [DISPARITY_DEPTH:0] D_MAX      = (DISPARITY_DEPTH+1)'(MAX_DISPARITY);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [PX_CNT_DEPTH:0]    r_x;
   logic [PX_CNT_DEPTH:0]    w_x_nxt;
   logic [LINE_CNT_DEPTH:0]  r_y;
   logic [LINE_CNT_DEPTH:0]  w_y_nxt;
   logic [LINE_CNT_DEPTH:0]  r_lcnt;
   logic [LINE_CNT_DEPTH:0]  w_lcnt_nxt;
   logic                     w_x_wrap;
   logic                     w_latch;
   logic [1:0]               r_pat;
   logic [DISPARITY_DEPTH:0] r_disp;
   logic [DISPARITY_DEPTH:0] w_disp_clamped;
   logic [PX_CNT_DEPTH+1:0]  w_xl;
   logic [PX_CNT_DEPTH+1:0]  w_xr;
   logic                     w_r_valid;
   logic [PIXEL_DEPTH:0]     w_px_l;
   logic [PIXEL_DEPTH:0]     w_px_r;

   assign w_disp_clamped = (iDisparity > D_MAX) ? D_MAX : iDisparity;

   always_comb begin
      w_x_wrap    = (r_x == X_LAST);
      w_x_nxt     = w_x_wrap ? '0 : r_x + 1'b1;
      w_y_nxt     = r_y;
      w_lcnt_nxt  = r_lcnt;
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_x_nxt    = '0;
            w_y_nxt    = '0;
            w_lcnt_nxt = '0;
            if (iEnable) begin
               w_state_nxt = ST_VSYNC;
               w_latch     = 1'b1;
            end
         end
         ST_VSYNC: begin
            if (w_x_wrap) begin
               if (r_lcnt == VS_LAST) begin
                  w_state_nxt = ST_VBLANK;
                  w_lcnt_nxt  = '0;
               end else begin
                  w_lcnt_nxt = r_lcnt + 1'b1;
               end
            end
         end
         ST_VBLANK: begin
            if (w_x_wrap) begin
               if (r_lcnt == VB_LAST) begin
                  w_state_nxt = ST_LINE;
                  w_lcnt_nxt  = '0;
                  w_y_nxt     = '0;
               end else begin
                  w_lcnt_nxt = r_lcnt + 1'b1;
               end
            end
         end
         ST_LINE: begin
            if (r_x == X_ACT_LAST) w_state_nxt = ST_HBLANK;
         end
         ST_HBLANK: begin
            if (w_x_wrap) begin
               if (r_y < Y_LAST) begin
                  w_y_nxt     = r_y + 1'b1;
                  w_state_nxt = ST_LINE;
               end else begin
                  w_y_nxt = '0;
                  if (iEnable) begin
                     w_state_nxt = ST_VSYNC;
                     w_latch     = 1'b1;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Pixels are generated from the next column so outputs line up with oHref.
   assign w_xl      = {1'b0, w_x_nxt};
   assign w_xr      = w_xl + (PX_CNT_DEPTH+2)'(r_disp);
   assign w_r_valid = (w_xr <= X_ACT_W);

   stereo_pattern_gen #(
      .PIXEL_DEPTH (PIXEL_DEPTH),
      .XW          (PX_CNT_DEPTH+2),
      .YW          (LINE_CNT_DEPTH+1)
   ) u_pat_l (
      .i_x       (w_xl),
      .i_y       (w_y_nxt),
      .i_pattern (r_pat),
      .o_px      (w_px_l)
   );

   stereo_pattern_gen #(
      .PIXEL_DEPTH (PIXEL_DEPTH),
      .XW          (PX_CNT_DEPTH+2),
      .YW          (LINE_CNT_DEPTH+1)
   ) u_pat_r (
      .i_x       (w_xr),
      .i_y       (w_y_nxt),
      .i_pattern (r_pat),
      .o_px      (w_px_r)
   );

   always_ff @(posedge pxclk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_lcnt     <= '0;
         r_pat      <= '0;
         r_disp     <= '0;
         oGrayL     <= '0;
         oGrayR     <= '0;
         oHref      <= 1'b0;
         oVsync     <= 1'b0;
         oLine      <= '0;
         oFrameDone <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_lcnt  <= w_lcnt_nxt;
         if (w_latch) begin
            r_pat  <= iPattern;
            r_disp <= w_disp_clamped;
         end
         oVsync     <= (w_state_nxt == ST_VSYNC);
         oHref      <= (w_state_nxt == ST_LINE);
         oGrayL     <= (w_state_nxt == ST_LINE) ? w_px_l : '0;
         oGrayR     <= (w_state_nxt == ST_LINE && w_r_valid) ? w_px_r : '0;
         oLine      <= (w_state_nxt == ST_LINE || w_state_nxt == ST_HBLANK) ? w_y_nxt : '0;
         oFrameDone <= (r_state == ST_LINE) && (w_state_nxt == ST_HBLANK) && (r_y == Y_LAST);
      end
   end

endmodule

// File: tb/tb_stereo_frame_source.sv
// tb/tb_stereo_frame_source.sv - directed checks of framing, patterns and disparity
module tb_stereo_frame_source;

   localparam int AP  = 7;
   localparam int AL  = 12;
   localparam int AFR = 72;

   logic pxclk = 1'b0;
   logic rst_n = 1'b0;
   always #5 pxclk = ~pxclk;

   logic        en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
   logic [1:0]  pat_a = 2'd0, pat_b = 2'd0, pat_c = 2'd0;
   logic [4:0]  disp_a = 5'd0, disp_b = 5'd0, disp_c = 5'd0;

   logic [18:0] gl_a, gr_a, gl_b, gr_b, gl_c, gr_c;
   logic        href_a, vs_a, fd_a, href_b, vs_b, fd_b, href_c, vs_c, fd_c;
   logic [9:0]  line_a, line_b, line_c;
   logic [50:0] got_a;

   assign got_a = {vs_a, href_a, fd_a, line_a, gl_a, gr_a};

   int n_cmp = 0;
   int n_bad = 0;

   stereo_frame_source #(
      .PIXELS_PER_LINE(AP), .LINES_PER_FRAME(3), .H_BLANK(4), .VSYNC_LINES(1), .V_BLANK(1)
   ) u_dut_a (
      .pxclk(pxclk), .reset(rst_n), .iEnable(en_a), .iPattern(pat_a), .iDisparity(disp_a),
      .oGrayL(gl_a), .oGrayR(gr_a), .oHref(href_a), .oVsync(vs_a), .oLine(line_a), .oFrameDone(fd_a)
   );

   stereo_frame_source #(
      .PIXELS_PER_LINE(31), .LINES_PER_FRAME(3), .H_BLANK(4), .VSYNC_LINES(1), .V_BLANK(1)
   ) u_dut_b (
      .pxclk(pxclk), .reset(rst_n), .iEnable(en_b), .iPattern(pat_b), .iDisparity(disp_b),
      .oGrayL(gl_b), .oGrayR(gr_b), .oHref(href_b), .oVsync(vs_b), .oLine(line_b), .oFrameDone(fd_b)
   );

   stereo_frame_source u_dut_c (
      .pxclk(pxclk), .reset(rst_n), .iEnable(en_c), .iPattern(pat_c), .iDisparity(disp_c),
      .oGrayL(gl_c), .oGrayR(gr_c), .oHref(href_c), .oVsync(vs_c), .oLine(line_c), .oFrameDone(fd_c)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [18:0] pxf(input int pat, input int x, input int y);
      case (pat)
         0:       return 19'(x);
         1:       return (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 19'h7FFFF : 19'h0;
         2:       return 19'(x ^ (y << 2));
         default: return 19'h0;
      endcase
   endfunction

   // Expected A outputs at frame cycle c (c=0 is the edge where oVsync rises); idle after the frame.
   function automatic logic [50:0] exp_a(input int c, input int pat, input int d);
      logic vs, href, fd;
      logic [9:0] ln;
      logic [18:0] gl, gr;
      int r, x, y;
      vs = 0; href = 0; fd = 0; ln = '0; gl = '0; gr = '0;
      if (c < AFR) begin
         if (c < AL) vs = 1;
         else if (c >= 2 * AL) begin
            r  = c - 2 * AL;
            y  = r / AL;
            x  = r % AL;
            ln = 10'(y);
            fd = (y == 3 && x == AP + 1);
            if (x <= AP) begin
               href = 1;
               gl   = pxf(pat, x, y);
               gr   = (x + d <= AP) ? pxf(pat, x + d, y) : 19'h0;
            end
         end
      end
      return {vs, href, fd, ln, gl, gr};
   endfunction

   task automatic run_a(input int pat, input int d, input int n, input int ev_c,
                        input logic ev_en, input logic [1:0] ev_pat, input logic [4:0] ev_disp);
      for (int c = 0; c < n; c++) begin
         @(posedge pxclk); #1;
         chk($sformatf("a_p%0d_d%0d_c%0d", pat, d, c), 64'(got_a), 64'(exp_a(c, pat, d)));
         if (c == ev_c) begin
            en_a = ev_en; pat_a = ev_pat; disp_a = ev_disp;
         end
      end
   endtask

   initial begin
      #1;
      chk("reset_a", 64'(got_a), 64'h0);
      repeat (2) @(posedge pxclk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge pxclk); #1;
         chk($sformatf("idle_a_%0d", i), 64'(got_a), 64'h0);
      end

      // Frame 1: ramp d=2; xor d=1 requested mid-frame for the next frame.
      en_a = 1'b1; pat_a = 2'd0; disp_a = 5'd2;
      run_a(0, 2, AFR, 40, 1'b1, 2'd2, 5'd1);
      // Frame 2: xor d=1; disparity goes to 5 and enable drops mid line 1.
      run_a(2, 1, AFR + 18, 40, 1'b0, 2'd2, 5'd5);
      // Frame 3 from IDLE picks up d=5.
      en_a = 1'b1; pat_a = 2'd0;
      run_a(0, 5, AFR + 8, 5, 1'b0, 2'd1, 5'd0);
      // Frame 4: checker, continuing into frame 5 ramp d=3.
      en_a = 1'b1;
      run_a(1, 0, AFR, 50, 1'b1, 2'd0, 5'd3);
      run_a(0, 3, 28, -1, 1'b1, 2'd0, 5'd3);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_a", 64'(got_a), 64'h0);
      #2 rst_n = 1'b1;
      run_a(0, 3, 3, -1, 1'b0, 2'd0, 5'd0);

      // Wide line, disparity clamped to 19.
      en_b = 1'b1; pat_b = 2'd0; disp_b = 5'd31;
      for (int c = 0; c < 2 * 36 + 32; c++) begin
         @(posedge pxclk); #1;
         if (c == 0) chk("b_vsync", 64'(vs_b), 64'h1);
         if (c == 71) chk("b_pre", 64'({href_b, gl_b, gr_b}), 64'h0);
         if (c >= 72)
            chk($sformatf("b_x%0d", c - 72), 64'({href_b, gl_b, gr_b}),
                64'({1'b1, 19'(c - 72), (c - 72 <= 12) ? 19'(c - 72 + 19) : 19'h0}));
      end
      en_b = 1'b0;

      // Default geometry checker: first line is dark for x<8, all-ones for 8..15.
      en_c = 1'b1; pat_c = 2'd1; disp_c = 5'd0;
      for (int c = 0; c < 2580 + 16; c++) begin
         @(posedge pxclk); #1;
         if (c == 0) chk("c_vsync", 64'(vs_c), 64'h1);
         if (c == 2579) chk("c_pre", 64'({href_c, gl_c}), 64'h0);
         if (c >= 2580)
            chk($sformatf("c_x%0d", c - 2580), 64'({href_c, gl_c}),
                64'({1'b1, (c - 2580 >= 8) ? 19'h7FFFF : 19'h0}));
      end
      en_c = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
